// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with run-time frame format
// (5..MAX_BITS data bits, optional odd/even parity) and a valid/ready
// output holding one word with frame, parity and overrun flags.
// Optional build macro UART_RX_MAJORITY_EN: each bit decision becomes a
// 2-of-3 vote of the samples at ticks OVS/2-1, OVS/2 and OVS/2+1.
module uart_rx_cfg #(
    parameter int MAX_BITS = 8,
    parameter int OVS      = 16
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Tick,
    input  logic                Rx,
    input  logic                RxEn,
    input  logic [3:0]          NBits,
    input  logic                ParityEn,
    input  logic                ParityOdd,
    input  logic                RxReady,
    output logic [MAX_BITS-1:0] RxData,
    output logic                RxValid,
    output logic                FrameErr,
    output logic                ParityErr,
    output logic                Overrun,
    output logic                Busy
);

    localparam int PW = $clog2(OVS);
    localparam logic [PW-1:0] LAST_PHASE = PW'(OVS - 1);
    // phase_r holds the number of ticks already seen in the current bit,
    // so the tick numbered k within the bit arrives while phase_r == k-1.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [PW-1:0] VOTE_A_PHASE = PW'(OVS / 2 - 2);
    localparam logic [PW-1:0] VOTE_B_PHASE = PW'(OVS / 2 - 1);
    localparam logic [PW-1:0] DEC_PHASE    = PW'(OVS / 2);
`else
    localparam logic [PW-1:0] DEC_PHASE    = PW'(OVS / 2 - 1);
`endif
    localparam logic [3:0] MAX_NB = 4'(MAX_BITS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity check: accumulated XOR of data and parity bit must equal the odd select.
    function automatic logic parity_bad(input logic acc, input logic odd);
        return acc ^ odd;
    endfunction

`ifdef UART_RX_MAJORITY_EN
    // 2-of-3 vote used for every bit decision.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    logic                rx_meta_r, rx_sync_r, rx_prev_r;
    logic [1:0]          init_cnt_r;
    state_t              state_r;
    logic [PW-1:0]       phase_r;
    logic [3:0]          bit_cnt_r;
    logic [3:0]          nbits_r;
    logic                par_en_r, par_odd_r, par_acc_r;
    logic [MAX_BITS-1:0] shift_r;
    logic                done_r, done_fe_r, done_pe_r;
    logic                sample_s, fall_s, dec_s;
    logic [3:0]          nbits_s;

    // Two-flop line synchronizer, edge-history flop, and a short arming
    // counter so a line that is already low at reset release is not taken
    // as a falling edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_prev_r  <= 1'b1;
            init_cnt_r <= 2'd0;
        end else begin
            rx_meta_r <= Rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
            if (init_cnt_r != 2'd3) begin
                init_cnt_r <= init_cnt_r + 2'd1;
            end else begin
                init_cnt_r <= init_cnt_r;
            end
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic vote_a_r, vote_b_r;

    // Capture the two early votes preceding each decision tick.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            vote_a_r <= 1'b1;
            vote_b_r <= 1'b1;
        end else begin
            if (Tick && (phase_r == VOTE_A_PHASE)) vote_a_r <= rx_sync_r;
            if (Tick && (phase_r == VOTE_B_PHASE)) vote_b_r <= rx_sync_r;
        end
    end
`endif

    // Bit decision value, start-edge detect, decision strobe and NBits clamp.
    always_comb begin
        sample_s = rx_sync_r;
`ifdef UART_RX_MAJORITY_EN
        sample_s = maj3(vote_a_r, vote_b_r, rx_sync_r);
`endif
        fall_s = (init_cnt_r == 2'd3) && rx_prev_r && !rx_sync_r;
        dec_s  = Tick && (phase_r == DEC_PHASE);
        if (NBits < 4'd5) begin
            nbits_s = 4'd5;
        end else if (NBits > MAX_NB) begin
            nbits_s = MAX_NB;
        end else begin
            nbits_s = NBits;
        end
    end

    // Frame FSM: tick phase counting, bit assembly and completion strobe.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r   <= ST_IDLE;
            Busy      <= 1'b0;
            phase_r   <= '0;
            bit_cnt_r <= 4'd0;
            nbits_r   <= 4'd0;
            par_en_r  <= 1'b0;
            par_odd_r <= 1'b0;
            par_acc_r <= 1'b0;
            shift_r   <= '0;
            done_r    <= 1'b0;
            done_fe_r <= 1'b0;
            done_pe_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (Tick) begin
                phase_r <= (phase_r == LAST_PHASE) ? '0 : phase_r + PW'(1);
            end
            if ((state_r != ST_IDLE) && !RxEn) begin
                state_r <= ST_IDLE;
                Busy    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        phase_r <= '0;
                        if (RxEn && fall_s) begin
                            state_r   <= ST_START;
                            Busy      <= 1'b1;
                            nbits_r   <= nbits_s;
                            par_en_r  <= ParityEn;
                            par_odd_r <= ParityOdd;
                            par_acc_r <= 1'b0;
                            bit_cnt_r <= 4'd0;
                            shift_r   <= '0;
                        end else begin
                            Busy <= 1'b0;
                        end
                    end
                    ST_START: begin
                        if (dec_s) begin
                            state_r <= sample_s ? ST_IDLE : ST_DATA;
                            Busy    <= !sample_s;
                        end
                    end
                    ST_DATA: begin
                        if (dec_s) begin
                            for (int i = 0; i < MAX_BITS; i++) begin
                                if (bit_cnt_r == 4'(i)) shift_r[i] <= sample_s;
                            end
                            par_acc_r <= par_acc_r ^ sample_s;
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (bit_cnt_r == (nbits_r - 4'd1)) begin
                                state_r <= par_en_r ? ST_PARITY : ST_STOP;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (dec_s) begin
                            par_acc_r <= par_acc_r ^ sample_s;
                            state_r   <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (dec_s) begin
                            state_r   <= ST_IDLE;
                            Busy      <= 1'b0;
                            done_r    <= 1'b1;
                            done_fe_r <= !sample_s;
                            done_pe_r <= par_en_r && parity_bad(par_acc_r, par_odd_r);
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        Busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Output word holding register with valid/ready handshake and overrun.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            RxData    <= '0;
            RxValid   <= 1'b0;
            FrameErr  <= 1'b0;
            ParityErr <= 1'b0;
            Overrun   <= 1'b0;
        end else if (done_r) begin
            if (!RxValid || RxReady) begin
                RxData    <= shift_r;
                FrameErr  <= done_fe_r;
                ParityErr <= done_pe_r;
                RxValid   <= 1'b1;
                Overrun   <= 1'b0;
            end else begin
                Overrun <= 1'b1;
            end
        end else if (RxValid && RxReady) begin
            RxValid <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            RxValid <= RxValid;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus random
// frames checked against a frame-level reference model.
module tb_uart_rx_cfg;

    localparam int MAXB = 8;
    localparam int OVS  = 16;
    localparam int TDIV = 4;
    localparam int BITC = OVS * TDIV;

    logic            Clk, Rst_n, Tick, Rx, RxEn, ParityEn, ParityOdd, RxReady;
    logic [3:0]      NBits;
    logic [MAXB-1:0] RxData;
    logic            RxValid, FrameErr, ParityErr, Overrun, Busy;

    int checks   = 0;
    int failures = 0;
    int vcyc     = 0;
    logic [10:0] obs_q[$];

    uart_rx_cfg #(.MAX_BITS(MAXB), .OVS(OVS)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .Rx(Rx), .RxEn(RxEn),
        .NBits(NBits), .ParityEn(ParityEn), .ParityOdd(ParityOdd),
        .RxReady(RxReady), .RxData(RxData), .RxValid(RxValid),
        .FrameErr(FrameErr), .ParityErr(ParityErr), .Overrun(Overrun), .Busy(Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // One-cycle Tick every TDIV clocks.
    initial begin
        int c;
        c = 0;
        Tick = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            c = (c + 1) % TDIV;
            Tick = (c == 0);
        end
    end

    // Record valid cycles and every accepted word {Overrun, ParityErr, FrameErr, RxData}.
    always @(negedge Clk) begin
        if (RxValid) vcyc = vcyc + 1;
        if (RxValid && RxReady) obs_q.push_back({Overrun, ParityErr, FrameErr, RxData});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Frame-level model: word size after clamping to 5..MAXB.
    function automatic int eff_bits(input int nb);
        if (nb < 5) return 5;
        if (nb > MAXB) return MAXB;
        return nb;
    endfunction

    task automatic send_frame(input logic [8:0] data, input int n, input bit pen,
                              input bit pbit, input bit stop);
        Rx = 1'b0;
        wait_clks(BITC);
        for (int i = 0; i < n; i++) begin
            Rx = data[i];
            wait_clks(BITC);
        end
        if (pen) begin
            Rx = pbit;
            wait_clks(BITC);
        end
        Rx = stop;
        wait_clks(BITC);
        Rx = 1'b1;
        wait_clks(2 * BITC);
    endtask

    task automatic expect_word(input string tag, input logic [7:0] d, input bit fe,
                               input bit pe, input bit ov);
        logic [10:0] w;
        chk({tag, "_count"}, obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            w = obs_q.pop_front();
            chk({tag, "_data"}, w[7:0], d);
            chk({tag, "_frame_err"}, w[8], fe);
            chk({tag, "_parity_err"}, w[9], pe);
            chk({tag, "_overrun"}, w[10], ov);
        end
        obs_q.delete();
    endtask

    initial begin
        logic [8:0] rd;
        int         nb, ne, ones;
        bit         pen, odd, pbit, stop, epe;
        logic [7:0] mask, ew;

        Rst_n = 1'b0; Rx = 1'b1; RxEn = 1'b1; NBits = 4'd8;
        ParityEn = 1'b0; ParityOdd = 1'b0; RxReady = 1'b1;
        wait_clks(3);
        chk("rst_data", RxData, 0);
        chk("rst_valid", RxValid, 0);
        chk("rst_ferr", FrameErr, 0);
        chk("rst_perr", ParityErr, 0);
        chk("rst_ovr", Overrun, 0);
        chk("rst_busy", Busy, 0);
        Rst_n = 1'b1;
        wait_clks(BITC);

        // 8N1 0xA5
        obs_q.delete(); vcyc = 0;
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1);
        expect_word("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("a5_valid_cycles", vcyc, 1);

        // 7 bits, even parity, wrong parity bit
        NBits = 4'd7; ParityEn = 1'b1; ParityOdd = 1'b0;
        send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1);
        expect_word("par41", 8'h41, 1'b0, 1'b1, 1'b0);

        // framing error then clean frame
        NBits = 4'd8; ParityEn = 1'b0;
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0);
        expect_word("fe3c", 8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(9'h055, 8, 1'b0, 1'b0, 1'b1);
        expect_word("clean55", 8'h55, 1'b0, 1'b0, 1'b0);

        // overrun
        RxReady = 1'b0; vcyc = 0;
        send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1);
        send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1);
        chk("ovr_valid", RxValid, 1);
        chk("ovr_data", RxData, 8'h11);
        chk("ovr_flag", Overrun, 1);
        RxReady = 1'b1;
        wait_clks(1);
        RxReady = 1'b0;
        wait_clks(2);
        chk("ovr_valid_clr", RxValid, 0);
        chk("ovr_flag_clr", Overrun, 0);
        expect_word("ovr_hs", 8'h11, 1'b0, 1'b0, 1'b1);
        RxReady = 1'b1;

        // 4-tick glitch is a false start
        vcyc = 0;
        Rx = 1'b0;
        wait_clks(2 * TDIV);
        chk("glitch_busy", Busy, 1);
        wait_clks(2 * TDIV);
        Rx = 1'b1;
        wait_clks(2 * BITC);
        chk("glitch_idle", Busy, 0);
        chk("glitch_novalid", vcyc, 0);
        chk("glitch_noword", obs_q.size(), 0);

        // RxEn drop mid-frame
        Rx = 1'b0;
        wait_clks(BITC + BITC / 2);
        RxEn = 1'b0;
        wait_clks(2);
        chk("rxen_abort_busy", Busy, 0);
        Rx = 1'b1;
        wait_clks(3 * BITC);
        RxEn = 1'b1;
        chk("rxen_novalid", vcyc, 0);
        send_frame(9'h096, 8, 1'b0, 1'b0, 1'b1);
        expect_word("rxen_recover", 8'h96, 1'b0, 1'b0, 1'b0);

`ifdef UART_RX_MAJORITY_EN
        // one-tick low glitch in the middle of bit 4 of 0xF0
        Rx = 1'b0; wait_clks(BITC);
        for (int i = 0; i < 8; i++) begin
            Rx = (i >= 4);
            if (i == 4) begin
                wait_clks(BITC / 2 - TDIV / 2);
                Rx = 1'b0; wait_clks(TDIV);
                Rx = 1'b1; wait_clks(BITC / 2 - TDIV / 2);
            end else begin
                wait_clks(BITC);
            end
        end
        Rx = 1'b1; wait_clks(3 * BITC);
        expect_word("maj_f0", 8'hF0, 1'b0, 1'b0, 1'b0);
`endif

        // reset during bit 3 with a word pending
        RxReady = 1'b0;
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1);
        chk("pend_valid", RxValid, 1);
        rd = 9'h081;
        Rx = 1'b0; wait_clks(BITC);
        for (int i = 0; i < 3; i++) begin
            Rx = rd[i]; wait_clks(BITC);
        end
        Rx = rd[3]; wait_clks(BITC / 2);
        chk("mid_busy", Busy, 1);
        Rst_n = 1'b0;
        #1;
        chk("mrst_data", RxData, 0);
        chk("mrst_valid", RxValid, 0);
        chk("mrst_busy", Busy, 0);
        chk("mrst_ovr", Overrun, 0);
        chk("mrst_errs", {FrameErr, ParityErr}, 0);
        wait_clks(3);
        Rst_n = 1'b1;
        RxReady = 1'b1;
        obs_q.delete(); vcyc = 0;
        wait_clks(BITC);
        Rx = 1'b1;
        wait_clks(2 * BITC);
        chk("mrst_no_restart", vcyc, 0);
        chk("mrst_idle", Busy, 0);
        send_frame(9'h081, 8, 1'b0, 1'b0, 1'b1);
        expect_word("after_rst_81", 8'h81, 1'b0, 1'b0, 1'b0);

        // random frames vs. frame-level model
        for (int k = 0; k < 12; k++) begin
            rd   = 9'($urandom);
            nb   = $urandom_range(0, 15);
            pen  = $urandom_range(0, 1);
            odd  = $urandom_range(0, 1);
            pbit = $urandom_range(0, 1);
            stop = ($urandom_range(0, 3) != 0);
            ne   = eff_bits(nb);
            mask = 8'((1 << ne) - 1);
            ew   = rd[7:0] & mask;
            ones = $countones(ew) + int'(pbit);
            epe  = pen && ((ones % 2) != int'(odd));
            NBits = 4'(nb); ParityEn = pen; ParityOdd = odd;
            vcyc = 0;
            send_frame(rd, ne, pen, pbit, stop);
            expect_word($sformatf("rnd%0d", k), ew, !stop, epe, 1'b0);
            chk($sformatf("rnd%0d_valid_cycles", k), vcyc, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
